// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and redirect flush generation.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic [2:0]      RegWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      MemWriteD,
    input  logic [3:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic [2:0]      ImmSrcD,
    input  logic            PCSrcE,
    input  logic            StallExt,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [2:0]      RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      MemWriteE,
    output logic [3:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [2:0]      ImmSrcE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE,
    output logic [31:0]     LoadStallCnt,
    output logic [31:0]     FlushCnt
);
    localparam int W = 5 * XLEN + 3 * 5 + 3 + 2 + 3 + 4 + 1 + 1 + 1 + 3;

    logic [W-1:0] d_bus, e_d, e_q;
    logic         lu;

    assign d_bus = {PCD, PCPlus4D, ImmExtD, RD1D, RD2D, Rs1D, Rs2D, RdD, RegWriteD,
                    ResultSrcD, MemWriteD, ALUControlD, ALUSrcD, BranchD, JumpD, ImmSrcD};
    assign {PCE, PCPlus4E, ImmExtE, RD1E, RD2E, Rs1E, Rs2E, RdE, RegWriteE,
            ResultSrcE, MemWriteE, ALUControlE, ALUSrcE, BranchE, JumpE, ImmSrcE} = e_q;

    assign lu     = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
    // A redirect makes the D instruction wrong-path, so it must not stall.
    assign StallF = (lu && !PCSrcE) || StallExt;
    assign StallD = StallF;
    assign FlushD = PCSrcE;
    assign FlushE = (lu || PCSrcE) && !StallExt;

    // An all-zero bubble also zeroes the register addresses, so forwarding sees nothing.
    always_comb e_d = StallExt ? e_q : FlushE ? '0 : d_bus;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) e_q <= '0;
        else        e_q <= e_d;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] ls_d, ls_q, fc_d, fc_q;

    always_comb begin
        ls_d = (lu && !PCSrcE && !StallExt && ~&ls_q) ? ls_q + 32'd1 : ls_q;
        fc_d = (PCSrcE && !StallExt && ~&fc_q) ? fc_q + 32'd1 : fc_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ls_q <= '0;
            fc_q <= '0;
        end else begin
            ls_q <= ls_d;
            fc_q <= fc_d;
        end

    assign LoadStallCnt = ls_q;
    assign FlushCnt     = fc_q;
`else
    assign LoadStallCnt = '0;
    assign FlushCnt     = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven check of the ID/EX register, hazard outputs and counters.
module tb_id_ex_stage;
    logic        clk = 0, rst_n = 0;
    logic [31:0] PCD, PCPlus4D, ImmExtD, RD1D, RD2D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [2:0]  RegWriteD, MemWriteD, ImmSrcD;
    logic [1:0]  ResultSrcD;
    logic [3:0]  ALUControlD;
    logic        ALUSrcD, BranchD, JumpD, PCSrcE, StallExt;
    logic [31:0] PCE, PCPlus4E, ImmExtE, RD1E, RD2E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [2:0]  RegWriteE, MemWriteE, ImmSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic        ALUSrcE, BranchE, JumpE, StallF, StallD, FlushD, FlushE;
    logic [31:0] LoadStallCnt, FlushCnt;
    int          n_chk = 0, n_fail = 0;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .RD1D(RD1D), .RD2D(RD2D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .BranchD(BranchD), .JumpD(JumpD),
        .ImmSrcD(ImmSrcD), .PCSrcE(PCSrcE), .StallExt(StallExt),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .RD1E(RD1E), .RD2E(RD2E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
        .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE), .ImmSrcE(ImmSrcE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .LoadStallCnt(LoadStallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  rsrc;
        logic [2:0]  rw;
        logic        pcsrc, sx, stall, fd, fe;
        logic [31:0] epc;
        logic [4:0]  ers1, ers2, erd;
        logic [1:0]  ersrc;
        logic [2:0]  erw;
    } vec_t;

    vec_t v[23];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // The remaining D fields are derived from the row so each E field is distinguishable
    // and a bubble (all-zero row) maps to all-zero values.
    task automatic drive(input vec_t r);
        PCD = r.pc; PCPlus4D = r.pc * 3; ImmExtD = r.pc << 4; RD1D = -r.pc; RD2D = r.pc * 5;
        Rs1D = r.rs1; Rs2D = r.rs2; RdD = r.rd; RegWriteD = r.rw; ResultSrcD = r.rsrc;
        MemWriteD = r.rs2[2:0]; ImmSrcD = r.rs1[2:0]; ALUControlD = r.rd[3:0];
        ALUSrcD = r.rd[4]; BranchD = r.rs1[3]; JumpD = r.rs2[3];
        PCSrcE = r.pcsrc; StallExt = r.sx;
    endtask

    task automatic chk_haz(input string t, input logic s, input logic fd, input logic fe);
        chk({t, " StallF"}, 32'(StallF), 32'(s));
        chk({t, " StallD"}, 32'(StallD), 32'(s));
        chk({t, " FlushD"}, 32'(FlushD), 32'(fd));
        chk({t, " FlushE"}, 32'(FlushE), 32'(fe));
    endtask

    task automatic chk_e(input string t, input vec_t r);
        chk({t, " PCE"}, PCE, r.epc);
        chk({t, " PCPlus4E"}, PCPlus4E, r.epc * 3);
        chk({t, " ImmExtE"}, ImmExtE, r.epc << 4);
        chk({t, " RD1E"}, RD1E, -r.epc);
        chk({t, " RD2E"}, RD2E, r.epc * 5);
        chk({t, " Rs1E"}, 32'(Rs1E), 32'(r.ers1));
        chk({t, " Rs2E"}, 32'(Rs2E), 32'(r.ers2));
        chk({t, " RdE"}, 32'(RdE), 32'(r.erd));
        chk({t, " RegWriteE"}, 32'(RegWriteE), 32'(r.erw));
        chk({t, " ResultSrcE"}, 32'(ResultSrcE), 32'(r.ersrc));
        chk({t, " MemWriteE"}, 32'(MemWriteE), 32'(r.ers2[2:0]));
        chk({t, " ImmSrcE"}, 32'(ImmSrcE), 32'(r.ers1[2:0]));
        chk({t, " ALUControlE"}, 32'(ALUControlE), 32'(r.erd[3:0]));
        chk({t, " ALUSrcE"}, 32'(ALUSrcE), 32'(r.erd[4]));
        chk({t, " BranchE"}, 32'(BranchE), 32'(r.ers1[3]));
        chk({t, " JumpE"}, 32'(JumpE), 32'(r.ers2[3]));
    endtask

    initial begin
        vec_t z, r;
        int   exp_ls, exp_fc;
        //        pc     rs1 rs2 rd rsrc rw pcs sx  st fd fe  epc    ers1 ers2 erd ersrc erw
        v[0]  = '{32'h0,   0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 32'h0,   0,  0,  0, 0, 0};
        v[1]  = v[0];
        v[2]  = v[0];
        v[3]  = '{32'h100, 1,  2,  5, 1, 2, 0, 0,  0, 0, 0, 32'h100, 1,  2,  5, 1, 2};
        v[4]  = '{32'h104, 5,  7,  6, 0, 2, 0, 0,  1, 0, 1, 32'h0,   0,  0,  0, 0, 0};
        v[5]  = '{32'h104, 5,  7,  6, 0, 2, 0, 0,  0, 0, 0, 32'h104, 5,  7,  6, 0, 2};
        v[6]  = '{32'h108, 3,  0,  8, 1, 2, 0, 0,  0, 0, 0, 32'h108, 3,  0,  8, 1, 2};
        v[7]  = '{32'h10c, 9,  8, 10, 0, 2, 1, 0,  0, 1, 1, 32'h0,   0,  0,  0, 0, 0};
        v[8]  = '{32'h200, 8,  0, 11, 0, 2, 0, 0,  0, 0, 0, 32'h200, 8,  0, 11, 0, 2};
        v[9]  = '{32'h204, 1,  0, 12, 1, 2, 0, 0,  0, 0, 0, 32'h204, 1,  0, 12, 1, 2};
        v[10] = '{32'h300, 12, 0, 13, 0, 2, 1, 1,  1, 1, 0, 32'h204, 1,  0, 12, 1, 2};
        v[11] = '{32'h304, 12, 0, 14, 0, 2, 1, 1,  1, 1, 0, 32'h204, 1,  0, 12, 1, 2};
        v[12] = '{32'h308, 12, 0, 15, 0, 2, 1, 1,  1, 1, 0, 32'h204, 1,  0, 12, 1, 2};
        v[13] = '{32'h30c, 12, 0, 16, 0, 2, 1, 1,  1, 1, 0, 32'h204, 1,  0, 12, 1, 2};
        v[14] = '{32'h310, 1,  2, 17, 0, 2, 0, 0,  0, 0, 0, 32'h310, 1,  2, 17, 0, 2};
        v[15] = '{32'h400, 0,  0,  0, 1, 2, 0, 0,  0, 0, 0, 32'h400, 0,  0,  0, 1, 2};
        v[16] = '{32'h404, 0,  0,  3, 0, 2, 0, 0,  0, 0, 0, 32'h404, 0,  0,  3, 0, 2};
        v[17] = '{32'h500, 1,  2,  9, 1, 2, 0, 0,  0, 0, 0, 32'h500, 1,  2,  9, 1, 2};
        v[18] = '{32'h504, 4,  9,  5, 1, 2, 0, 0,  1, 0, 1, 32'h0,   0,  0,  0, 0, 0};
        v[19] = '{32'h504, 4,  9,  5, 1, 2, 0, 0,  0, 0, 0, 32'h504, 4,  9,  5, 1, 2};
        v[20] = '{32'h508, 5,  0,  6, 0, 2, 0, 0,  1, 0, 1, 32'h0,   0,  0,  0, 0, 0};
        v[21] = '{32'h508, 5,  0,  6, 0, 2, 1, 0,  0, 1, 1, 32'h0,   0,  0,  0, 0, 0};
        v[22] = '{32'h600, 5,  5,  7, 0, 2, 0, 0,  0, 0, 0, 32'h600, 5,  5,  7, 0, 2};
        z = v[0];
`ifdef ID_EX_PERF_CNT_EN
        exp_ls = 3; exp_fc = 2;
`else
        exp_ls = 0; exp_fc = 0;
`endif
        drive(z);
        #2;
        chk_e("reset", z);
        chk_haz("reset", 0, 0, 0);
        chk("reset LoadStallCnt", LoadStallCnt, 0);
        chk("reset FlushCnt", FlushCnt, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 23; i++) begin
            drive(v[i]);
            #1;
            chk_haz($sformatf("row%0d", i), v[i].stall, v[i].fd, v[i].fe);
            @(posedge clk);
            #1;
            chk_e($sformatf("row%0d", i), v[i]);
            @(negedge clk);
        end
        chk("LoadStallCnt", LoadStallCnt, 32'(exp_ls));
        chk("FlushCnt", FlushCnt, 32'(exp_fc));
        // Asynchronous reset in the middle of a cycle, with hazard outputs probed while held.
        r = '{32'h700, 6, 7, 8, 0, 2, 0, 0, 0, 0, 0, 32'h700, 6, 7, 8, 0, 2};
        drive(r);
        #1;
        rst_n = 0;
        #1;
        chk_e("async_rst", z);
        chk("async_rst LoadStallCnt", LoadStallCnt, 0);
        chk("async_rst FlushCnt", FlushCnt, 0);
        StallExt = 1; PCSrcE = 1;
        #1;
        chk_haz("rst sx+pcsrc", 1, 1, 0);
        StallExt = 0;
        #1;
        chk_haz("rst pcsrc", 0, 1, 1);
        PCSrcE = 0;
        #0.5;
        rst_n = 1;
        #0.5;
        chk_haz("rst release", 0, 0, 0);
        @(posedge clk);
        #1;
        chk_e("after release", r);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the pipelined RV32 core, with the load-use hazard detector and control-hazard flush logic attached. It captures decoded operands and control from ID. It presents the E-stage copies (Rs1E, Rs2E, RdE, RegWriteE, ImmSrcE, …) that the forwarding unit and the ALU consume. It also generates the stall and flush controls for the F/D/E registers.

## Interface
- XLEN, 32, datapath width
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- PCD, PCPlus4D, ImmExtD, RD1D, RD2D  in  XLEN each  decoded PC values, immediate and register-file read data
- Rs1D, Rs2D, RdD  in  5 each  register addresses
- RegWriteD  in  3  write-back type; 0 = no write
- ResultSrcD  in  2  result select; 2'b01 = load from memory
- MemWriteD  in  3  store type; 0 = no store
- ALUControlD  in  4  ALU operation
- ALUSrcD, BranchD, JumpD  in  1 each  operand-B select, branch, jump
- ImmSrcD  in  3  immediate format
- PCSrcE  in  1  taken branch/jump resolved in E (redirect)
- StallExt  in  1  data-memory busy; freezes the whole front end
- *E outputs  out  same widths  registered copies of every *D input above
- StallF, StallD  out  1 each  hold PC / IF-ID register
- FlushD, FlushE  out  1 each  bubble IF-ID register / this register
- LoadStallCnt, FlushCnt  out  32 each  performance counters (see Configuration)

## Operation
- Load-use hazard: lu = (ResultSrcE==2'b01) && (RdE!=0) && ((Rs1D==RdE) || (Rs2D==RdE)).
- StallF = StallD = (lu && !PCSrcE) || StallExt.
- FlushD = PCSrcE.
- FlushE = (lu || PCSrcE) && !StallExt.
- Register update priority on each clock edge:
  1. StallExt: hold all E fields.
  2. Else FlushE: load a bubble.
  3. Else: capture all D inputs.
- Bubble = RegWriteE=0, MemWriteE=0, ResultSrcE=0, BranchE=0, JumpE=0, Rs1E=Rs2E=RdE=0, ImmSrcE=0. Data fields (PC, immediates, read data) are don't-care; they are zeroed.
- Zeroed register addresses make the forwarding unit select "no forward" for a bubble.
- Redirect with a simultaneous load-use: the flush wins. The instruction in D is wrong-path, so no stall is raised.
- Load in E with RdE=0: no stall.
- A load-use condition persists for exactly one cycle. After the bubble, ResultSrcE=0 and lu drops.

## Timing
- Reset (asynchronous, rst_n low): all E outputs read 0 immediately; counters read 0. Hazard outputs follow combinationally from the zeroed state: StallF = StallD = StallExt, FlushD = PCSrcE.
- E outputs have 1-cycle latency from the D inputs.
- Hazard outputs are combinational from the current E registers, Rs1D/Rs2D, PCSrcE and StallExt. They are valid within the same cycle and have no registered delay.
- A load-use costs exactly 1 bubble cycle. A redirect costs 2 slots (D and E flushed).
- Reset deasserted mid-stall: the first edge after release captures the D inputs normally.

## Configuration
- ID_EX_PERF_CNT_EN defined:
  - LoadStallCnt increments on every edge where lu && !PCSrcE && !StallExt.
  - FlushCnt increments on every edge where PCSrcE && !StallExt.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by reset.
- Undefined: no counter logic; LoadStallCnt and FlushCnt are tied to 0. Ports exist in both builds.

## Test plan
- Reset then release, D inputs all 0 for 3 cycles → all E outputs 0, StallF/StallD/FlushD/FlushE = 0.
- Cycle 1: lw x5 (RdD=5, ResultSrcD=01, RegWriteD=3'b010) enters E. Cycle 2: D holds Rs1D=5 → StallF=StallD=FlushE=1. Next edge: E is a bubble (RegWriteE=0, Rs1E=0). D input unchanged. Cycle 3: lu=0, and the add is captured with Rs1E=5.
- Same load-use pattern with PCSrcE=1 in cycle 2 → StallF=StallD=0, FlushD=FlushE=1. Next edge: bubble in E.
- StallExt=1 for 4 cycles with changing D inputs and PCSrcE=1 → E outputs frozen, FlushE=0, StallF=StallD=1. The update resumes on the first edge after StallExt drops.
- lw with RdD=0 followed by Rs1D=0 → no stall, no flush.
- With ID_EX_PERF_CNT_EN: 3 load-use events and 2 redirects → LoadStallCnt=3, FlushCnt=2. rst_n pulse mid-run → both 0 asynchronously.
